// File: rtl/controle_tranca_pkg.sv
// rtl/controle_tranca_pkg.sv - shared types and widths for the latch controller
package tranca_pkg;

    localparam int TIMER_W  = 8;
    localparam int FALHAS_W = 4;

    typedef enum logic [1:0] {
        FECHADO  = 2'd0,
        ABERTO   = 2'd1,
        BLOQUEIO = 2'd2
    } estado_t;

endpackage

// File: rtl/controle_tranca_if.sv
// rtl/controle_tranca_if.sv - attempt/relock inputs and latch status outputs
interface controle_tranca_if;
    import tranca_pkg::*;

    logic                aberto;
    logic                tentar;
    logic                fechar;
    logic                trava_liberada;
    logic                bloqueado;
    logic [FALHAS_W-1:0] falhas;
    logic                alarme;

    modport master (
        output aberto, tentar, fechar,
        input  trava_liberada, bloqueado, falhas, alarme
    );

    modport slave (
        input  aberto, tentar, fechar,
        output trava_liberada, bloqueado, falhas, alarme
    );
endinterface

// File: rtl/controle_tranca_contador.sv
// rtl/controle_tranca_contador.sv - loadable down-counter shared by open and lockout timers
module contador_regressivo
    import tranca_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               en,
    output logic               zero
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // load has priority so a state entry always restarts the timer cleanly
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/controle_tranca.sv
// rtl/controle_tranca.sv - timed latch release with failure counting and lockout
module controle_tranca
    import tranca_pkg::*;
#(
    parameter int OPEN_CYCLES    = 8,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    controle_tranca_if.slave         bus
);

    localparam logic [TIMER_W-1:0]  OPEN_LOAD = TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0]  LOCK_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FALHAS_W:0]   FAIL_LIM  = (FALHAS_W + 1)'(MAX_FAIL);

    estado_t             state_q, state_d;
    logic [FALHAS_W-1:0] falhas_q, falhas_d;
    logic                alarme_q, alarme_d;
    logic                trava_q, trava_d;
    logic                bloq_q, bloq_d;

    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmr_en;
    logic               tmr_zero;
    logic [FALHAS_W:0]  falhas_inc;

    contador_regressivo u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    assign falhas_inc = {1'b0, falhas_q} + 1'b1;

    always_comb begin
        state_d  = state_q;
        falhas_d = falhas_q;
        alarme_d = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_en   = 1'b0;

        case (state_q)
            FECHADO: begin
                // tentar takes precedence; fechar is meaningless while closed
                if (bus.tentar) begin
                    if (bus.aberto) begin
                        state_d  = ABERTO;
                        falhas_d = '0;
                        tmr_load = 1'b1;
                        tmr_val  = OPEN_LOAD;
                    end else if (falhas_inc >= FAIL_LIM) begin
                        state_d  = BLOQUEIO;
                        falhas_d = FALHAS_W'(MAX_FAIL);
                        alarme_d = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = LOCK_LOAD;
                    end else begin
                        falhas_d = falhas_inc[FALHAS_W-1:0];
                    end
                end
            end
            ABERTO: begin
                if (bus.fechar || tmr_zero) begin
                    state_d = FECHADO;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            BLOQUEIO: begin
                if (tmr_zero) begin
                    state_d  = FECHADO;
                    falhas_d = '0;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: begin
                state_d  = FECHADO;
                falhas_d = '0;
            end
        endcase

        // decode from next state so the status flags are registered alongside it
        trava_d = (state_d == ABERTO);
        bloq_d  = (state_d == BLOQUEIO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FECHADO;
            falhas_q <= '0;
            alarme_q <= 1'b0;
            trava_q  <= 1'b0;
            bloq_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            falhas_q <= falhas_d;
            alarme_q <= alarme_d;
            trava_q  <= trava_d;
            bloq_q   <= bloq_d;
        end
    end

    assign bus.trava_liberada = trava_q;
    assign bus.bloqueado      = bloq_q;
    assign bus.falhas         = falhas_q;
    assign bus.alarme         = alarme_q;

endmodule

// File: tb/tb_controle_tranca.sv
// tb/tb_controle_tranca.sv - directed vector bench for the latch controller
module tb_controle_tranca;
    import tranca_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    controle_tranca_if bus ();
    controle_tranca_if bus1 ();

    controle_tranca #(.OPEN_CYCLES(8), .MAX_FAIL(3), .LOCKOUT_CYCLES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    controle_tranca #(.OPEN_CYCLES(8), .MAX_FAIL(1), .LOCKOUT_CYCLES(16)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    typedef struct {
        logic       t;
        logic       a;
        logic       f;
        logic       tr;
        logic       bl;
        logic [3:0] fa;
        logic       al;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic t, input logic a, input logic f,
                                input logic tr, input logic bl,
                                input logic [3:0] fa, input logic al);
        vec_t v;
        v.t = t; v.a = a; v.f = f; v.tr = tr; v.bl = bl; v.fa = fa; v.al = al;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic tr, input logic bl,
                           input logic [3:0] fa, input logic al);
        chk({nm, " trava"},  {3'b0, bus.trava_liberada}, {3'b0, tr});
        chk({nm, " bloq"},   {3'b0, bus.bloqueado},      {3'b0, bl});
        chk({nm, " falhas"}, bus.falhas,                 fa);
        chk({nm, " alarme"}, {3'b0, bus.alarme},         {3'b0, al});
    endtask

    initial begin
        bus.tentar = 0;  bus.aberto = 0;  bus.fechar = 0;
        bus1.tentar = 0; bus1.aberto = 0; bus1.fechar = 0;

        // correct attempt: eight open cycles, then closed
        add(1,1,0, 1,0,0,0);
        repeat (7) add(0,0,0, 1,0,0,0);
        add(0,0,0, 0,0,0,0);
        // early relock on the third open cycle, wrong tentar ignored while open
        add(1,1,0, 1,0,0,0);
        add(1,0,0, 1,0,0,0);
        add(0,0,0, 1,0,0,0);
        add(0,0,1, 0,0,0,0);
        add(0,0,0, 0,0,0,0);
        // tentar beats fechar while closed; fechar alone does nothing
        add(1,1,1, 1,0,0,0);
        add(0,0,1, 0,0,0,0);
        add(0,0,1, 0,0,0,0);
        // two failures then a success clears the count
        add(1,0,0, 0,0,1,0);
        add(0,0,0, 0,0,1,0);
        add(1,0,0, 0,0,2,0);
        add(1,1,0, 1,0,0,0);
        repeat (7) add(0,0,0, 1,0,0,0);
        add(0,0,0, 0,0,0,0);
        // separated failures reach lockout; attempts during lockout ignored
        add(1,0,0, 0,0,1,0);
        add(0,0,0, 0,0,1,0);
        add(1,0,0, 0,0,2,0);
        add(0,0,0, 0,0,2,0);
        add(1,0,0, 0,1,3,1);
        for (int i = 0; i < 15; i++) add(1'(i % 2), 1, i == 3, 0,1,3,0);
        add(0,0,0, 0,0,0,0);
        add(1,1,0, 1,0,0,0);
        add(0,0,1, 0,0,0,0);
        // held strobe counts one attempt per cycle
        add(1,0,0, 0,0,1,0);
        add(1,0,0, 0,0,2,0);
        add(1,0,0, 0,1,3,1);
        repeat (15) add(1,0,0, 0,1,3,0);
        add(0,0,0, 0,0,0,0);

        #2;
        chk_all("reset", 0, 0, 4'd0, 0);
        chk("reset1 bloq", {3'b0, bus1.bloqueado}, 4'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_all("idle", 0, 0, 4'd0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            bus.tentar = vecs[i].t;
            bus.aberto = vecs[i].a;
            bus.fechar = vecs[i].f;
            @(posedge clk); #1;
            chk_all($sformatf("v%0d", i), vecs[i].tr, vecs[i].bl, vecs[i].fa, vecs[i].al);
        end
        bus.tentar = 0; bus.aberto = 0; bus.fechar = 0;

        // single wrong attempt locks out when MAX_FAIL is 1
        bus1.tentar = 1; bus1.aberto = 0;
        @(posedge clk); #1;
        bus1.tentar = 0;
        chk("mf1 bloq",   {3'b0, bus1.bloqueado},      4'd1);
        chk("mf1 falhas", bus1.falhas,                 4'd1);
        chk("mf1 alarme", {3'b0, bus1.alarme},         4'd1);
        chk("mf1 trava",  {3'b0, bus1.trava_liberada}, 4'd0);
        @(posedge clk); #1;
        chk("mf1 alarme2", {3'b0, bus1.alarme},    4'd0);
        chk("mf1 bloq2",   {3'b0, bus1.bloqueado}, 4'd1);

        // asynchronous reset between edges while open
        bus.tentar = 1; bus.aberto = 1;
        @(posedge clk); #1;
        bus.tentar = 0; bus.aberto = 0;
        chk_all("pre_rst", 1, 0, 4'd0, 0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 4'd0, 0);
        chk("async_rst1 bloq", {3'b0, bus1.bloqueado}, 4'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_all("post_rst", 0, 0, 4'd0, 0);
        @(posedge clk); #1;
        chk_all("post_rst2", 0, 0, 4'd0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/controle_tranca.md
Name: controle_tranca

Overview:
Sequential controller directly downstream of the cadeado combinational lock. It consumes cadeado's `aberto` flag together with a user "try" strobe, and drives the physical latch release for a bounded time. It counts consecutive wrong attempts and enters a timed lockout with an alarm pulse after MAX_FAIL failures.

Parameters:
OPEN_CYCLES, 8, cycles `trava_liberada` stays high after a correct attempt (legal range 1..255).
MAX_FAIL, 3, consecutive wrong attempts that trigger lockout (legal range 1..15).
LOCKOUT_CYCLES, 16, cycles `bloqueado` stays high (legal range 1..255).

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
aberto  input  1  code-match flag from cadeado; combinational, stable when `tentar` is high.
tentar  input  1  attempt strobe, sampled every cycle; level held N cycles = N attempts.
fechar  input  1  manual relock request.
trava_liberada  output  1  latch release drive.
bloqueado  output  1  lockout indicator.
falhas  output  4  current consecutive-failure count.
alarme  output  1  one-cycle pulse on lockout entry.

Behaviour:
- Reset (`rst_n` low, asynchronous): state=FECHADO, timer=0, trava_liberada=0, bloqueado=0, falhas=0, alarme=0. Applies mid-operation and overrides any state.
- All outputs are registered. An input sampled at edge k is reflected after edge k.
- Internal timer is 8 bits and loads with the parameter value minus 1.
- FECHADO:
  - tentar=1 and aberto=1: go to ABERTO, timer=OPEN_CYCLES-1, falhas=0.
  - tentar=1 and aberto=0 with falhas+1<MAX_FAIL: falhas+=1, stay in FECHADO.
  - tentar=1 and aberto=0 with falhas+1==MAX_FAIL: go to BLOQUEIO, timer=LOCKOUT_CYCLES-1, falhas=MAX_FAIL, alarme=1 for exactly one cycle.
  - fechar has no effect.
- ABERTO:
  - trava_liberada=1.
  - tentar is ignored, so falhas stays unchanged.
  - fechar=1: go to FECHADO next edge, regardless of timer.
  - Otherwise, timer==0: go to FECHADO; else timer-=1.
  - trava_liberada is therefore high for exactly OPEN_CYCLES cycles when fechar stays low.
- BLOQUEIO:
  - bloqueado=1 for exactly LOCKOUT_CYCLES cycles.
  - tentar and fechar are ignored.
  - timer==0: go to FECHADO, falhas=0.
- Simultaneous tentar and fechar in FECHADO: tentar wins.
- alarme is high only in the first cycle of BLOQUEIO.
- trava_liberada and bloqueado are mutually exclusive, never both 1.
- States are one-hot or binary; the encoding is free. Unreachable encodings return to FECHADO.

Decomposition:
- Shared package `tranca_pkg`: state enum (FECHADO, ABERTO, BLOQUEIO), timer width constant (8), falhas width constant (4).
- One natural sub-module, `contador_regressivo`: loadable 8-bit down-counter with load, enable and zero flag. It is used for both the open timer and the lockout timer.

Test Plan:
1. Reset: rst_n=0 asserted mid-ABERTO, asynchronously between edges -> all outputs 0 immediately, without waiting for an edge; after release, idle in FECHADO.
2. Correct attempt: aberto=1, one-cycle tentar -> trava_liberada=1 for exactly 8 cycles starting the cycle after the edge; falhas=0 throughout.
3. Early relock: correct attempt, then fechar=1 on the 3rd open cycle -> trava_liberada=0 after that edge; further tentar is ignored while open.
4. Failures below limit: two wrong tentar pulses, then a correct one -> falhas 1, 2, then 0; trava_liberada=1 for 8 cycles.
5. Lockout: three wrong tentar pulses -> third edge gives alarme=1 for one cycle and bloqueado=1 for 16 cycles. tentar with aberto=1 during lockout is ignored. Afterwards falhas=0 and bloqueado=0.
6. Held strobe: tentar held high for 3 cycles with aberto=0 -> lockout entered on the 3rd edge; parameter override MAX_FAIL=1 -> a single wrong attempt triggers lockout.
